dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_pick.sv | 24 ++
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, access
// owner encoding and default timing parameters.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_LD   = 1'b1
  } owner_e;

  localparam int DEF_LATENCY      = 2;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the MEM stage and the loader port.
// The pipeline wins by default; a waiting loader is forced ahead at the limit.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          pipe_req_i,
  input  logic          ld_valid_i,
  input  logic [SW-1:0] starve_cnt_i,
  input  logic          pipe_done_i,
  output logic          pipe_win_o,
  output logic          ld_win_o
);

  logic pipe_eff;

  // While pipe_done is high the request lines still describe the finished access.
  assign pipe_eff   = pipe_req_i & ~pipe_done_i;
  assign ld_win_o   = ld_valid_i & (~pipe_eff | (starve_cnt_i == SW'(STARVE_LIMIT)));
  assign pipe_win_o = pipe_eff & ~ld_win_o;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-ported data memory arbiter: sequences one access at a time over a
// fixed read latency, stalls the pipeline until its access completes.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int LATENCY      = DEF_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_memread,
  input  logic        pipe_memwrite,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  output logic        pipe_done,
  output logic [31:0] pipe_rdata,
  input  logic        ld_valid,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ready,
  output logic        ld_done,
  output logic [31:0] ld_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          pipe_done_q, pipe_done_d;
  logic [31:0]   pipe_rdata_q, pipe_rdata_d;
  logic          ld_done_q, ld_done_d;
  logic [31:0]   ld_rdata_q, ld_rdata_d;

  logic pipe_req;
  logic can_grant;
  logic pipe_win;
  logic ld_win;

  assign pipe_req  = pipe_memread | pipe_memwrite;
  assign can_grant = (state_q == IDLE) || (state_q == DONE);

  dmem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SW           (SW)
  ) u_pick (
    .pipe_req_i   (pipe_req),
    .ld_valid_i   (ld_valid),
    .starve_cnt_i (starve_q),
    .pipe_done_i  (pipe_done_q),
    .pipe_win_o   (pipe_win),
    .ld_win_o     (ld_win)
  );

  assign ld_ready   = can_grant & ld_win;
  assign pipe_stall = reset_n & pipe_req & ~pipe_done_q;

  assign pipe_done  = pipe_done_q;
  assign pipe_rdata = pipe_rdata_q;
  assign ld_done    = ld_done_q;
  assign ld_rdata   = ld_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pipe_done_d  = 1'b0;
    pipe_rdata_d = pipe_rdata_q;
    ld_done_d    = 1'b0;
    ld_rdata_d   = ld_rdata_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (ld_win) begin
          mem_en_d    = 1'b1;
          mem_we_d    = ld_we;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_wdata;
          owner_d     = OWN_LD;
          cnt_d       = CW'(LATENCY);
          starve_d    = '0;
          state_d     = WAIT;
        end else if (pipe_win) begin
          mem_en_d    = 1'b1;
          mem_we_d    = pipe_memwrite;
          mem_addr_d  = pipe_addr;
          mem_wdata_d = pipe_wdata;
          owner_d     = OWN_PIPE;
          cnt_d       = CW'(LATENCY);
          state_d     = WAIT;
          if (!ld_valid) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      WAIT: begin
        // cnt reaches zero in the cycle mem_rdata is valid for the strobe issued at grant.
        if (cnt_q == '0) begin
          if (owner_q == OWN_LD) begin
            ld_rdata_d = mem_rdata;
            ld_done_d  = 1'b1;
          end else begin
            pipe_rdata_d = mem_rdata;
            pipe_done_d  = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_PIPE;
      cnt_q        <= '0;
      starve_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pipe_done_q  <= 1'b0;
      pipe_rdata_q <= '0;
      ld_done_q    <= 1'b0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pipe_done_q  <= pipe_done_d;
      pipe_rdata_q <= pipe_rdata_d;
      ld_done_q    <= ld_done_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed per-cycle vector table, reset and LATENCY=1
// sequences, then random traffic checked against a transaction-level model.
module tb_dmem_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  logic        pipe_memread, pipe_memwrite, pipe_stall, pipe_done;
  logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic        ld_valid, ld_we, ld_ready, ld_done;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        p1_rd, p1_wr, p1_stall, p1_done;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        l1_valid, l1_we, l1_ready, l1_done;
  logic [31:0] l1_addr, l1_wdata, l1_rdata;
  logic        m1_en, m1_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;

  assign m1_rdata = 32'h0;

  dmem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(STARVE)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_memread(pipe_memread), .pipe_memwrite(pipe_memwrite),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_done(pipe_done), .pipe_rdata(pipe_rdata),
    .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.LATENCY(1), .STARVE_LIMIT(STARVE)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .pipe_memread(p1_rd), .pipe_memwrite(p1_wr),
    .pipe_addr(p1_addr), .pipe_wdata(p1_wdata),
    .pipe_stall(p1_stall), .pipe_done(p1_done), .pipe_rdata(p1_rdata),
    .ld_valid(l1_valid), .ld_we(l1_we), .ld_addr(l1_addr), .ld_wdata(l1_wdata),
    .ld_ready(l1_ready), .ld_done(l1_done), .ld_rdata(l1_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
  );

  // Memory model: read data appears LAT cycles after the mem_en cycle.
  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
    if (i == 4)  w = 32'hDEAD_BEEF;
    if (i == 16) w = 32'hCAFE_F00D;
    return w;
  endfunction

  logic        mem_init;
  logic [31:0] sim_mem [0:255];
  logic [31:0] rd_pipe [0:LAT-1];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= init_word(i);
    end else if (mem_en) begin
      rd_pipe[0] <= sim_mem[mem_addr[9:2]];
      if (mem_we) sim_mem[mem_addr[9:2]] <= mem_wdata;
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        prd, pwr;
    logic [31:0] paddr, pwdata;
    logic        lv, lwe;
    logic [31:0] laddr, lwdata;
    logic        e_stall, e_en, e_we, e_pdone, e_lready, e_ldone;
    logic [31:0] e_prdata, e_lrdata;
  } vec_t;

  function automatic vec_t mk(input logic prd, pwr, input logic [31:0] pa, pd,
                              input logic lv, lwe, input logic [31:0] la, lw,
                              input logic s, en, we, pdn, lr, ldn,
                              input logic [31:0] prdat, lrdat);
    vec_t v;
    v.prd = prd; v.pwr = pwr; v.paddr = pa; v.pwdata = pd;
    v.lv = lv; v.lwe = lwe; v.laddr = la; v.lwdata = lw;
    v.e_stall = s; v.e_en = en; v.e_we = we; v.e_pdone = pdn;
    v.e_lready = lr; v.e_ldone = ldn; v.e_prdata = prdat; v.e_lrdata = lrdat;
    return v;
  endfunction

  vec_t tbl [0:32];

  // Reference model state for the random phase.
  logic [31:0] ref_mem [0:255];
  int          t_done;
  logic        own_ld, own_we;
  logic [31:0] own_res;
  int          starve;

  initial begin
    int          cyc;
    logic        pr, pdn, ldn, free, peff, lwin, pwin, pd_prev, lw_prev;
    int          r;

    reset_n = 1'b0; mem_init = 1'b0;
    pipe_memread = 1'b1; pipe_memwrite = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    ld_valid = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    p1_rd = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wdata = '0;
    l1_valid = 1'b0; l1_we = 1'b0; l1_addr = '0; l1_wdata = '0;
    #3;
    check("rst_stall", {31'd0, pipe_stall}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_pipe_done", {31'd0, pipe_done}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ld_rdata", ld_rdata, 32'd0);
    pipe_memread = 1'b0;
    @(posedge clk); #1 mem_init = 1'b1;
    @(posedge clk); #1 mem_init = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    // Per-cycle directed table.
    tbl[0]  = mk(1,0,32'h10,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[1]  = mk(1,0,32'h10,0,     0,0,0,0,          1,1,0,0,0,0, 0,0);
    tbl[2]  = mk(1,0,32'h10,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[3]  = mk(1,0,32'h10,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[4]  = mk(1,0,32'h10,0,     0,0,0,0,          0,0,0,1,0,0, 32'hDEADBEEF,0);
    tbl[5]  = mk(0,0,0,0,          1,0,32'h40,0,     0,0,0,0,1,0, 0,0);
    tbl[6]  = mk(0,0,0,0,          0,0,0,0,          0,1,0,0,0,0, 0,0);
    tbl[7]  = mk(0,0,0,0,          0,0,0,0,          0,0,0,0,0,0, 0,0);
    tbl[8]  = mk(0,0,0,0,          0,0,0,0,          0,0,0,0,0,0, 0,0);
    tbl[9]  = mk(0,0,0,0,          0,0,0,0,          0,0,0,0,0,1, 0,32'hCAFEF00D);
    tbl[10] = mk(0,1,32'h20,32'h1234, 0,0,0,0,       1,0,0,0,0,0, 0,0);
    tbl[11] = mk(0,1,32'h20,32'h1234, 0,0,0,0,       1,1,1,0,0,0, 0,0);
    tbl[12] = mk(0,1,32'h20,32'h1234, 0,0,0,0,       1,0,0,0,0,0, 0,0);
    tbl[13] = mk(0,1,32'h20,32'h1234, 0,0,0,0,       1,0,0,0,0,0, 0,0);
    tbl[14] = mk(0,1,32'h20,32'h1234, 0,0,0,0,       0,0,0,1,0,0, 0,0);
    tbl[15] = mk(1,0,32'h20,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[16] = mk(1,0,32'h20,0,     0,0,0,0,          1,1,0,0,0,0, 0,0);
    tbl[17] = mk(1,0,32'h20,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[18] = mk(1,0,32'h20,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[19] = mk(1,0,32'h20,0,     0,0,0,0,          0,0,0,1,0,0, 32'h1234,0);
    tbl[20] = mk(1,0,32'h30,0,     1,1,32'h44,32'h55, 1,0,0,0,0,0, 0,0);
    tbl[21] = mk(1,0,32'h30,0,     1,1,32'h44,32'h55, 1,1,0,0,0,0, 0,0);
    tbl[22] = mk(1,0,32'h30,0,     1,1,32'h44,32'h55, 1,0,0,0,0,0, 0,0);
    tbl[23] = mk(1,0,32'h30,0,     1,1,32'h44,32'h55, 1,0,0,0,0,0, 0,0);
    tbl[24] = mk(1,0,32'h30,0,     1,1,32'h44,32'h55, 0,0,0,1,1,0, init_word(12),0);
    tbl[25] = mk(1,0,32'h10,0,     0,0,0,0,          1,1,1,0,0,0, 0,0);
    tbl[26] = mk(1,0,32'h10,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[27] = mk(1,0,32'h10,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[28] = mk(1,0,32'h10,0,     0,0,0,0,          1,0,0,0,0,1, 0,0);
    tbl[29] = mk(1,0,32'h10,0,     0,0,0,0,          1,1,0,0,0,0, 0,0);
    tbl[30] = mk(1,0,32'h10,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[31] = mk(1,0,32'h10,0,     0,0,0,0,          1,0,0,0,0,0, 0,0);
    tbl[32] = mk(1,0,32'h10,0,     0,0,0,0,          0,0,0,1,0,0, 32'hDEADBEEF,0);

    for (int i = 0; i <= 32; i++) begin
      @(posedge clk); #1;
      pipe_memread = tbl[i].prd; pipe_memwrite = tbl[i].pwr;
      pipe_addr = tbl[i].paddr; pipe_wdata = tbl[i].pwdata;
      ld_valid = tbl[i].lv; ld_we = tbl[i].lwe;
      ld_addr = tbl[i].laddr; ld_wdata = tbl[i].lwdata;
      @(negedge clk);
      $display("vec %0d: stall=%b en=%b we=%b pdone=%b lready=%b ldone=%b",
               i, pipe_stall, mem_en, mem_we, pipe_done, ld_ready, ld_done);
      check($sformatf("vec%0d_stall", i), {31'd0, pipe_stall}, {31'd0, tbl[i].e_stall});
      check($sformatf("vec%0d_mem_en", i), {31'd0, mem_en}, {31'd0, tbl[i].e_en});
      check($sformatf("vec%0d_mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].e_we});
      check($sformatf("vec%0d_pipe_done", i), {31'd0, pipe_done}, {31'd0, tbl[i].e_pdone});
      check($sformatf("vec%0d_ld_ready", i), {31'd0, ld_ready}, {31'd0, tbl[i].e_lready});
      check($sformatf("vec%0d_ld_done", i), {31'd0, ld_done}, {31'd0, tbl[i].e_ldone});
      if (tbl[i].e_pdone && tbl[i].e_prdata != 32'h0)
        check($sformatf("vec%0d_pipe_rdata", i), pipe_rdata, tbl[i].e_prdata);
      if (tbl[i].e_ldone && tbl[i].e_lrdata != 32'h0)
        check($sformatf("vec%0d_ld_rdata", i), ld_rdata, tbl[i].e_lrdata);
    end
    check("ld_write_mem", sim_mem[17], 32'h55);

    // Reset during WAIT of a pipeline load, then a fresh load.
    @(posedge clk); #1 pipe_memread = 1'b1; pipe_addr = 32'h40;
    @(posedge clk); @(posedge clk); #2 reset_n = 1'b0;
    #1;
    $display("reset mid-wait: en=%b addr=%h prdata=%h stall=%b", mem_en, mem_addr, pipe_rdata, pipe_stall);
    check("rstw_mem_en", {31'd0, mem_en}, 32'd0);
    check("rstw_mem_addr", mem_addr, 32'd0);
    check("rstw_pipe_rdata", pipe_rdata, 32'd0);
    check("rstw_stall", {31'd0, pipe_stall}, 32'd0);
    check("rstw_pipe_done", {31'd0, pipe_done}, 32'd0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("rel%0d_stall", k), {31'd0, pipe_stall}, {31'd0, (k < 4)});
      check($sformatf("rel%0d_done", k), {31'd0, pipe_done}, {31'd0, (k == 4)});
      check($sformatf("rel%0d_mem_en", k), {31'd0, mem_en}, {31'd0, (k == 1)});
    end
    check("rel_rdata", pipe_rdata, 32'hCAFEF00D);
    $display("post-reset load: rdata=%h", pipe_rdata);
    @(posedge clk); #1 pipe_memread = 1'b0;

    // LATENCY=1 instance: read and write together is a write.
    @(posedge clk); #1 p1_rd = 1'b1; p1_wr = 1'b1; p1_addr = 32'h8; p1_wdata = 32'h77;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("l1c%0d_mem_en", k), {31'd0, m1_en}, {31'd0, (k == 1)});
      check($sformatf("l1c%0d_mem_we", k), {31'd0, m1_we}, {31'd0, (k == 1)});
      check($sformatf("l1c%0d_done", k), {31'd0, p1_done}, {31'd0, (k == 3)});
      check($sformatf("l1c%0d_stall", k), {31'd0, p1_stall}, {31'd0, (k < 3)});
      if (k == 1) check("l1_wdata", m1_wdata, 32'h77);
    end
    $display("latency1 rd+wr: done=%b", p1_done);
    @(posedge clk); #1 p1_rd = 1'b0; p1_wr = 1'b0;

    // Random traffic against the transaction-level model.
    @(posedge clk); #1 mem_init = 1'b1;
    @(posedge clk); #1 mem_init = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    t_done = -1; own_ld = 1'b0; own_we = 1'b0; own_res = '0; starve = 0;
    pd_prev = 1'b1; lw_prev = 1'b1;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (pd_prev || !(pipe_memread || pipe_memwrite)) begin
        r = int'($urandom_range(0, 3));
        pipe_memread  = (r == 1) || (r == 3);
        pipe_memwrite = (r >= 2);
        pipe_addr     = 32'($urandom_range(0, 15)) << 2;
        pipe_wdata    = $urandom;
      end
      if (lw_prev || !ld_valid) begin
        ld_valid = ($urandom_range(0, 9) < 4);
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = 32'($urandom_range(0, 15)) << 2;
        ld_wdata = $urandom;
      end
      @(negedge clk);
      pr   = pipe_memread | pipe_memwrite;
      pdn  = (t_done == cyc) && !own_ld;
      ldn  = (t_done == cyc) && own_ld;
      free = (t_done < cyc);
      free = free || (t_done == cyc);
      peff = pr && !pdn;
      lwin = free && ld_valid && (!peff || starve == STARVE);
      pwin = free && peff && !lwin;
      check("rnd_stall", {31'd0, pipe_stall}, {31'd0, peff});
      check("rnd_ld_ready", {31'd0, ld_ready}, {31'd0, lwin});
      check("rnd_pipe_done", {31'd0, pipe_done}, {31'd0, pdn});
      check("rnd_ld_done", {31'd0, ld_done}, {31'd0, ldn});
      if (pdn && !own_we) check("rnd_pipe_rdata", pipe_rdata, own_res);
      if (ldn && !own_we) check("rnd_ld_rdata", ld_rdata, own_res);
      if (pdn || ldn)
        $display("rnd cyc %0d: %s %s data=%h", cyc, own_ld ? "ld" : "pipe",
                 own_we ? "wr" : "rd", own_ld ? ld_rdata : pipe_rdata);
      if (lwin || pwin) begin
        own_ld  = lwin;
        own_we  = lwin ? ld_we : pipe_memwrite;
        own_res = ref_mem[lwin ? ld_addr[9:2] : pipe_addr[9:2]];
        if (own_we) ref_mem[lwin ? ld_addr[9:2] : pipe_addr[9:2]] = lwin ? ld_wdata : pipe_wdata;
        t_done  = cyc + LAT + 2;
        if (lwin)          starve = 0;
        else if (ld_valid) starve = (starve < STARVE) ? starve + 1 : STARVE;
        else               starve = 0;
      end
      pd_prev = pdn;
      lw_prev = lwin;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
